// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the dmux_stream demultiplexer and its per-channel slots.
// Holds the channel-index width helper and the data register reset value.
package dmux_stream_pkg;

  // N=2 still needs a 1-bit index; $clog2 alone would give 1 there but 0 for N=1.
  function automatic int chan_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/dmux_slot.sv
// Single-entry output register for one demux channel; load-to-valid latency 1 cycle.
// Backpressure: free when empty or draining this cycle, so a load can replace a draining beat.
module dmux_slot
  import dmux_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             free_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  assign free_o  = ~valid_q | ready_i;
  assign data_o  = data_q;
  assign valid_o = valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= {WIDTH{DATA_RST_BIT}};
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// N-way valid/ready demultiplexer with broadcast and sticky bad-select error; latency 1 cycle.
// Backpressure: IN_READY follows the addressed slot (all slots for broadcast); bad selects are always accepted.
module dmux_stream
  import dmux_stream_pkg::*;
#(
  parameter int   WIDTH = 16,
  parameter int   N     = 4,
  localparam int  SELW  = chan_w(N)
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [WIDTH-1:0]   IN,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [SELW-1:0]    SEL,
  input  logic               BCAST,
  output logic [N*WIDTH-1:0] OUT,
  output logic [N-1:0]       OUT_VALID,
  input  logic [N-1:0]       OUT_READY,
  output logic               ERR,
  input  logic               CLR_ERR
);

  localparam logic [SELW:0] N_L = (SELW+1)'(N);

  logic [N-1:0] sel_oh;
  logic [N-1:0] slot_free;
  logic [N-1:0] slot_load;
  logic         sel_oob;
  logic         all_free;
  logic         sel_free;
  logic         accept;
  logic         drop;
  logic         err_q, err_d;

  assign sel_oob = ({1'b0, SEL} >= N_L);

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign sel_oh[k]    = ({1'b0, SEL} == (SELW+1)'(k));
    assign slot_load[k] = accept & (BCAST | sel_oh[k]);

    dmux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i   (CLK),
      .rst_ni  (RESET_N),
      .load_i  (slot_load[k]),
      .data_i  (IN),
      .ready_i (OUT_READY[k]),
      .data_o  (OUT[k*WIDTH +: WIDTH]),
      .valid_o (OUT_VALID[k]),
      .free_o  (slot_free[k])
    );
  end

  assign all_free = &slot_free;
  assign sel_free = |(sel_oh & slot_free);

  // A broadcast waits for every slot so no channel ever sees half of it.
  assign IN_READY = RESET_N & (BCAST ? all_free : (sel_oob | sel_free));
  assign accept   = IN_VALID & IN_READY;
  assign drop     = accept & ~BCAST & sel_oob;

  assign err_d = drop | (err_q & ~CLR_ERR);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_dmux_stream.sv
// Bench for dmux_stream: directed vector table, hand sequences and a randomized model check.
// Instance A is N=4 (power of two), instance B is N=3 to reach the out-of-range select path.
module tb_dmux_stream;

  localparam int W  = 16;
  localparam int NA = 4;
  localparam int NB = 3;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_n;

  logic [W-1:0]    a_in;
  logic            a_vld, a_rdy, a_bcast, a_err, a_clr;
  logic [1:0]      a_sel;
  logic [NA*W-1:0] a_out;
  logic [NA-1:0]   a_ov, a_ordy;

  logic [W-1:0]    b_in;
  logic            b_vld, b_rdy, b_bcast, b_err, b_clr;
  logic [1:0]      b_sel;
  logic [NB*W-1:0] b_out;
  logic [NB-1:0]   b_ov, b_ordy;

  dmux_stream #(.WIDTH(W), .N(NA)) u_a (
    .CLK(CLK), .RESET_N(rst_n), .IN(a_in), .IN_VALID(a_vld), .IN_READY(a_rdy),
    .SEL(a_sel), .BCAST(a_bcast), .OUT(a_out), .OUT_VALID(a_ov), .OUT_READY(a_ordy),
    .ERR(a_err), .CLR_ERR(a_clr)
  );

  dmux_stream #(.WIDTH(W), .N(NB)) u_b (
    .CLK(CLK), .RESET_N(rst_n), .IN(b_in), .IN_VALID(b_vld), .IN_READY(b_rdy),
    .SEL(b_sel), .BCAST(b_bcast), .OUT(b_out), .OUT_VALID(b_ov), .OUT_READY(b_ordy),
    .ERR(b_err), .CLR_ERR(b_clr)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic        bcast;
    logic [15:0] din;
    logic [3:0]  ordy;
    logic        exp_rdy;
    logic [3:0]  exp_ov;
    int          ch;
    logic [15:0] exp_dat;
  } vec_t;

  vec_t vt[20];

  // Sender-side rule: a stalled offer must be held until accepted.
  logic        p_stall = 1'b0;
  logic        p_vld, p_bcast;
  logic [1:0]  p_sel;
  logic [15:0] p_in;
  always @(posedge CLK) begin
    if (p_stall) begin
      tests++;
      if ({a_vld, a_bcast, a_sel, a_in} !== {p_vld, p_bcast, p_sel, p_in}) begin
        fails++;
        $display("FAIL hold_rule: got %h expected %h",
                 {a_vld, a_bcast, a_sel, a_in}, {p_vld, p_bcast, p_sel, p_in});
      end
    end
    p_stall <= rst_n & a_vld & ~a_rdy;
    p_vld   <= a_vld;
    p_bcast <= a_bcast;
    p_sel   <= a_sel;
    p_in    <= a_in;
  end

  // Called at posedge+1; checks IN_READY before the edge and state after it.
  task automatic apply_a(input vec_t v, input int idx);
    a_vld = v.vld; a_sel = v.sel; a_bcast = v.bcast; a_in = v.din; a_ordy = v.ordy;
    @(negedge CLK);
    check($sformatf("vec%0d_rdy", idx), a_rdy, v.exp_rdy);
    @(posedge CLK); #1;
    check($sformatf("vec%0d_ov", idx), a_ov, v.exp_ov);
    check($sformatf("vec%0d_dat", idx), a_out[v.ch*W +: W], v.exp_dat);
  endtask

  logic        m_vld[NA];
  logic [15:0] m_dat[NA];

  initial begin
    logic exp_rdy, acc, stall;
    logic [NA-1:0] exp_ov;

    vt[0]  = '{1'b1, 2'd0, 1'b0, 16'hA000, 4'b1111, 1'b1, 4'b0001, 0, 16'hA000};
    vt[1]  = '{1'b1, 2'd1, 1'b0, 16'hA001, 4'b1111, 1'b1, 4'b0010, 1, 16'hA001};
    vt[2]  = '{1'b1, 2'd2, 1'b0, 16'hA002, 4'b1111, 1'b1, 4'b0100, 2, 16'hA002};
    vt[3]  = '{1'b1, 2'd3, 1'b0, 16'hA003, 4'b1111, 1'b1, 4'b1000, 3, 16'hA003};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 3, 16'hA003};
    vt[5]  = '{1'b1, 2'd2, 1'b0, 16'h1234, 4'b1011, 1'b1, 4'b0100, 2, 16'h1234};
    vt[6]  = '{1'b1, 2'd2, 1'b0, 16'h5678, 4'b1011, 1'b0, 4'b0100, 2, 16'h1234};
    vt[7]  = '{1'b1, 2'd2, 1'b0, 16'h5678, 4'b1111, 1'b1, 4'b0100, 2, 16'h5678};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 2, 16'h5678};
    vt[9]  = '{1'b1, 2'd1, 1'b0, 16'h1111, 4'b1101, 1'b1, 4'b0010, 1, 16'h1111};
    vt[10] = '{1'b1, 2'd3, 1'b0, 16'hBEEF, 4'b1101, 1'b1, 4'b1010, 3, 16'hBEEF};
    vt[11] = '{1'b0, 2'd1, 1'b0, 16'h0000, 4'b1101, 1'b0, 4'b0010, 1, 16'h1111};
    vt[12] = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 1, 16'h1111};
    vt[13] = '{1'b1, 2'd0, 1'b0, 16'hC0C0, 4'b1110, 1'b1, 4'b0001, 0, 16'hC0C0};
    vt[14] = '{1'b1, 2'd0, 1'b1, 16'hFFFF, 4'b1110, 1'b0, 4'b0001, 0, 16'hC0C0};
    vt[15] = '{1'b1, 2'd0, 1'b1, 16'hFFFF, 4'b1111, 1'b1, 4'b1111, 0, 16'hFFFF};
    vt[16] = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b1111, 3, 16'hFFFF};
    vt[17] = '{1'b0, 2'd0, 1'b0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 3, 16'hFFFF};
    vt[18] = '{1'b1, 2'd0, 1'b0, 16'h0001, 4'b1111, 1'b1, 4'b0001, 0, 16'h0001};
    vt[19] = '{1'b1, 2'd0, 1'b0, 16'h0002, 4'b1111, 1'b1, 4'b0001, 0, 16'h0002};

    rst_n = 1'b0;
    a_vld = 1'b1; a_sel = 2'd0; a_bcast = 1'b0; a_in = 16'h0; a_ordy = '1; a_clr = 1'b0;
    b_vld = 1'b1; b_sel = 2'd0; b_bcast = 1'b0; b_in = 16'h0; b_ordy = '1; b_clr = 1'b0;
    #12;
    check("rst_a_ov",  a_ov,  '0);
    check("rst_a_out", a_out, '0);
    check("rst_a_rdy", a_rdy, 1'b0);
    check("rst_a_err", a_err, 1'b0);
    check("rst_b_rdy", b_rdy, 1'b0);
    check("rst_b_err", b_err, 1'b0);
    b_vld = 1'b0;
    @(negedge CLK); rst_n = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 20; i++) apply_a(vt[i], i);
    a_vld = 1'b0;

    // Out-of-range select and sticky ERR on the N=3 instance.
    b_vld = 1'b1; b_sel = 2'd2; b_in = 16'h3333;
    @(negedge CLK); check("b_top_rdy", b_rdy, 1'b1);
    @(posedge CLK); #1;
    check("b_top_ov", b_ov, 3'b100);
    check("b_top_dat", b_out[2*W +: W], 16'h3333);
    b_sel = 2'd3; b_in = 16'h9999;
    @(negedge CLK); check("b_oob_rdy", b_rdy, 1'b1);
    check("b_oob_err_pre", b_err, 1'b0);
    @(posedge CLK); #1;
    check("b_oob_err", b_err, 1'b1);
    check("b_oob_ov", b_ov, 3'b000);
    b_vld = 1'b0;
    @(posedge CLK); #1;
    check("b_err_held", b_err, 1'b1);
    b_clr = 1'b1;
    @(posedge CLK); #1;
    b_clr = 1'b0;
    check("b_err_clr", b_err, 1'b0);
    b_vld = 1'b1; b_sel = 2'd3; b_clr = 1'b1;
    @(posedge CLK); #1;
    b_vld = 1'b0; b_clr = 1'b0;
    check("b_err_set_wins", b_err, 1'b1);

    // Asynchronous reset with channels 0 and 2 holding beats.
    a_ordy = 4'b0000; a_vld = 1'b1; a_sel = 2'd0; a_in = 16'h1111;
    @(posedge CLK); #1;
    a_sel = 2'd2; a_in = 16'h2222;
    @(posedge CLK); #1;
    a_vld = 1'b0;
    check("pre_arst_ov", a_ov, 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov",    a_ov,  '0);
    check("arst_out",   a_out, '0);
    check("arst_rdy",   a_rdy, 1'b0);
    check("arst_b_err", b_err, 1'b0);
    @(negedge CLK); rst_n = 1'b1;
    @(posedge CLK); #1;
    a_ordy = '1; a_vld = 1'b1; a_sel = 2'd0; a_in = 16'hA000;
    @(negedge CLK); check("post_arst_rdy", a_rdy, 1'b1);
    @(posedge CLK); #1;
    check("post_arst_ov", a_ov, 4'b0001);
    check("post_arst_dat", a_out[0 +: W], 16'hA000);
    a_vld = 1'b0;

    @(negedge CLK); rst_n = 1'b0;
    @(negedge CLK); rst_n = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < NA; k++) begin m_vld[k] = 1'b0; m_dat[k] = 16'h0; end

    // Randomized traffic against the channel-slot model.
    stall = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!stall) begin
        a_vld   = ($urandom_range(0, 3) != 0);
        a_bcast = ($urandom_range(0, 7) == 0);
        a_sel   = 2'($urandom_range(0, 3));
        a_in    = 16'($urandom);
      end
      a_ordy = 4'($urandom) | 4'($urandom);
      @(negedge CLK);
      for (int k = 0; k < NA; k++) begin
        exp_ov[k] = m_vld[k];
        if (m_vld[k]) check($sformatf("rnd%0d_dat%0d", c, k), a_out[k*W +: W], m_dat[k]);
      end
      check($sformatf("rnd%0d_ov", c), a_ov, exp_ov);
      if (a_bcast) begin
        exp_rdy = 1'b1;
        for (int k = 0; k < NA; k++) if (m_vld[k] && !a_ordy[k]) exp_rdy = 1'b0;
      end else begin
        exp_rdy = !m_vld[a_sel] || a_ordy[a_sel];
      end
      check($sformatf("rnd%0d_rdy", c), a_rdy, exp_rdy);
      acc = a_vld && exp_rdy;
      for (int k = 0; k < NA; k++) begin
        if (acc && (a_bcast || a_sel == 2'(k))) begin
          m_vld[k] = 1'b1;
          m_dat[k] = a_in;
        end else if (a_ordy[k]) begin
          m_vld[k] = 1'b0;
        end
      end
      stall = a_vld && !exp_rdy;
      @(posedge CLK); #1;
    end
    a_vld = 1'b0;
    check("a_err_never", a_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmux_stream.md
Name: dmux_stream

Overview:
- Parametrised N-way, WIDTH-bit demultiplexer with valid/ready flow control. Successor to the combinational 1-bit 4-way demux.
- One input stream is routed to one of N output channels by SEL, or to all channels in broadcast mode.
- Each channel has a one-entry output register, so a stalled consumer blocks only traffic addressed to it.
- Sits between the instruction/data fetch path and peripheral or memory-mapped sinks.

Parameters:
- WIDTH, 16: data width in bits.
- N, 4: number of output channels, 2..16.
- SELW, $clog2(N): SEL width. Derived; not overridden.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- IN  in  WIDTH  input data.
- IN_VALID  in  1  input beat offered.
- IN_READY  out  1  input beat accepted this cycle when IN_VALID=1.
- SEL  in  SELW  destination channel index; sampled with the beat.
- BCAST  in  1  broadcast beat to all N channels; SEL ignored when set.
- OUT  out  N*WIDTH  packed channel data; channel k is OUT[k*WIDTH +: WIDTH].
- OUT_VALID  out  N  per-channel valid.
- OUT_READY  in  N  per-channel ready.
- ERR  out  1  sticky flag: a beat with out-of-range SEL was dropped.
- CLR_ERR  in  1  synchronous clear of ERR.

Behaviour:
- Reset (RESET_N=0, asynchronous): all OUT_VALID=0, OUT=0, ERR=0. IN_READY=0 while reset is asserted.
- Reset mid-operation: buffered beats are discarded. No partial broadcast survives reset.
- Channel slot k:
  - Free when OUT_VALID[k]=0, or when OUT_VALID[k]=1 and OUT_READY[k]=1 in the same cycle (pass-through drain).
  - A slot holds its data and valid stable until OUT_READY[k]=1. Data must not change while valid and not ready.
- Unicast (BCAST=0, SEL<N): IN_READY = slot[SEL] free.
  - On accept (IN_VALID and IN_READY), the next cycle has OUT[SEL]=IN and OUT_VALID[SEL]=1.
  - Latency is 1 cycle. Throughput is 1 beat/cycle per channel when the consumer holds ready high.
- Broadcast (BCAST=1): IN_READY = all N slots free.
  - On accept, every slot loads IN and every OUT_VALID goes to 1 on the next cycle, atomically.
  - No partial broadcast: a broadcast is never accepted while any slot is blocked.
- Out-of-range SEL (SEL>=N, possible only when N is not a power of two, BCAST=0): IN_READY=1 and the beat is consumed and dropped. ERR sets on the next cycle.
- ERR is sticky. CLR_ERR=1 clears it on the next edge. If CLR_ERR and a new error occur in the same cycle, the set wins and ERR=1.
- IN_READY is combinational from SEL, BCAST, OUT_VALID and OUT_READY. It does not depend on IN_VALID.
- Independent drains: channels drain independently. Any subset of OUT_READY may be high in a cycle.
- Simultaneous load and drain on slot k: the new beat replaces the drained beat and OUT_VALID[k] stays 1.
- N=2 is a legal configuration with SELW=1.
- A sender may change SEL, BCAST or IN while IN_VALID=0. While IN_VALID=1 and IN_READY=0, the sender must hold them stable. The bench asserts this rather than the RTL.

Decomposition:
- Shared package: the channel-index width function (clog2 wrapper) and the reset value of the data register (zero).
- One natural sub-module, dmux_slot: a single-entry register with load, data, valid, ready and free. It is instantiated N times in a generate loop.
- The top level holds only the select decode (the generalised DMux4Way one-hot), the broadcast all-free AND-reduce, the IN_READY mux and the ERR flag.

Test Plan:
- Unicast sweep (N=4, WIDTH=16, all OUT_READY=1): IN=16'hA000+k, SEL=k for k=0..3 on consecutive cycles. Each OUT[k]=16'hA000+k with OUT_VALID[k] pulsing exactly one cycle after its accept; IN_READY stays 1.
- Backpressure: OUT_READY[2]=0, send SEL=2 data 16'h1234 then SEL=2 data 16'h5678. The second beat sees IN_READY=0, OUT[2] holds 16'h1234. Raising OUT_READY[2] accepts 16'h5678 in the same cycle, and OUT[2]=16'h5678 on the next cycle.
- Isolation: OUT_READY[1]=0 with channel 1 full. A SEL=3 beat 16'hBEEF is accepted immediately and OUT[3]=16'hBEEF on the next cycle; channel 1 is unchanged.
- Broadcast gating: channel 0 full and stalled, BCAST=1 with data 16'hFFFF. IN_READY=0 and no channel loads. Releasing OUT_READY[0] accepts the beat, and on the next cycle all OUT_VALID=4'b1111 with every OUT slice 16'hFFFF.
- Error path (N=3, SEL=2'b11): beat accepted, no OUT_VALID rises, ERR=1 on the next cycle and held. CLR_ERR=1 for one cycle gives ERR=0. CLR_ERR coincident with another bad SEL leaves ERR=1.
- Async reset: assert RESET_N=0 mid-cycle with channels 0 and 2 full. OUT_VALID=0 and ERR=0 immediately, without waiting for a clock edge. After release, the first accepted beat behaves as in the unicast sweep.
